// File: rtl/kernel_kcore_deg_update_if.sv
// FIFO-facing bus of the k-core degree updater: edge-stream read side and peel-stream write side.
// master = the updater, slave = the FIFO pair/environment driving it.
interface kernel_kcore_deg_update_if;
    logic        in_empty_n;
    logic        in_read;
    logic [63:0] in_dout;
    logic        out_full_n;
    logic        out_write;
    logic [31:0] out_din;

    modport master (
        input  in_empty_n, in_dout, out_full_n,
        output in_read, out_write, out_din
    );

    modport slave (
        output in_empty_n, in_dout, out_full_n,
        input  in_read, out_write, out_din
    );
endinterface

// File: rtl/kernel_kcore_deg_update.sv
// Residual-degree table for k-core peeling: pops edge words, decrements dst degree, emits ids crossing k -> k-1.
// Optional KCORE_DEG_STATS_EN adds edge_cnt and min_deg statistics outputs.
module kernel_kcore_deg_update #(
    parameter int NUM_V = 64,
    parameter int VID_W = 6,
    parameter int DEG_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    kernel_kcore_deg_update_if.master fifo,
    input  logic [DEG_W-1:0]      cfg_k,
    input  logic                  init_we,
    input  logic [VID_W-1:0]      init_addr,
    input  logic [DEG_W-1:0]      init_data,
    output logic [31:0]           peel_cnt,
    output logic [15:0]           err_cnt
`ifdef KCORE_DEG_STATS_EN
    ,
    output logic [31:0]           edge_cnt,
    output logic [DEG_W-1:0]      min_deg
`endif
);

    logic [DEG_W-1:0] deg_tbl [NUM_V];

    logic             hold_v;
    logic [31:0]      hold_id;

    logic [31:0]      vid;
    logic [VID_W-1:0] idx;
    logic             in_range;
    logic             init_ok;
    logic [DEG_W-1:0] old_deg;
    logic             pop;
    logic             dec;
    logic             emit;
    logic             xfer;
    logic [31:0]      unused_src;

    assign vid        = fifo.in_dout[31:0];
    assign unused_src = fifo.in_dout[63:32];
    assign idx        = vid[VID_W-1:0];
    assign in_range   = vid < 32'(NUM_V);

    // Only a table smaller than the address space can see out-of-range init writes.
    generate
        if (NUM_V < (1 << VID_W)) begin : g_init_chk
            assign init_ok = init_addr < VID_W'(NUM_V);
        end else begin : g_init_all
            assign init_ok = 1'b1;
        end
    endgenerate

    // Combinational read so the RMW finishes within the pop cycle.
    assign old_deg = deg_tbl[idx];

    assign pop  = ~reset & fifo.in_empty_n & ~init_we & (~hold_v | fifo.out_full_n);
    assign dec  = pop & in_range & (old_deg != '0);
    assign emit = pop & in_range & (cfg_k != '0) & (old_deg == cfg_k);
    assign xfer = hold_v & fifo.out_full_n;

    assign fifo.in_read   = pop;
    assign fifo.out_write = hold_v;
    assign fifo.out_din   = hold_id;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_V; i++) deg_tbl[i] <= '0;
        end else if (init_we) begin
            if (init_ok) deg_tbl[init_addr] <= init_data;
        end else if (dec) begin
            deg_tbl[idx] <= old_deg - DEG_W'(1);
        end
    end

    // Holding register: a new emission always wins; a transfer alone empties it.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_v  <= 1'b0;
            hold_id <= '0;
        end else if (emit) begin
            hold_v  <= 1'b1;
            hold_id <= vid;
        end else if (xfer) begin
            hold_v  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            peel_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            if (xfer) peel_cnt <= peel_cnt + 32'd1;
            if (pop && !in_range && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        end
    end

`ifdef KCORE_DEG_STATS_EN
    logic [DEG_W-1:0] new_deg;
    assign new_deg = old_deg - DEG_W'(1);

    // min_deg tracks post-decrement values that are still nonzero.
    always_ff @(posedge clk) begin
        if (reset) begin
            edge_cnt <= '0;
            min_deg  <= '1;
        end else begin
            if (pop) edge_cnt <= edge_cnt + 32'd1;
            if (dec && new_deg != '0 && new_deg < min_deg) min_deg <= new_deg;
        end
    end
`endif

endmodule

// File: doc/kernel_kcore_deg_update.md
Name: kernel_kcore_deg_update

Overview:
- Downstream consumer of the 64-bit edge stream FIFO (ap_fifo read side: empty_n/read/dout).
- Holds a per-vertex residual-degree table and decrements the destination vertex's degree for each popped edge word.
- When a vertex's degree falls from exactly k to k-1, pushes its 32-bit id into the next-stage peel FIFO (ap_fifo write side: full_n/write/din).
- Host or control logic preloads degrees via an init write port.

Parameters:
- NUM_V, 64, number of vertices in the degree table (entries 0..NUM_V-1).
- VID_W, 6, vertex index width used for table addressing (clog2(NUM_V)).
- DEG_W, 16, degree counter width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_empty_n  in  1  upstream FIFO has data; in_dout valid while high.
- in_read  out  1  pop strobe to upstream FIFO.
- in_dout  in  64  edge word; [31:0] = dst vertex id, [63:32] = src id (ignored).
- out_full_n  in  1  downstream FIFO can accept.
- out_write  out  1  push strobe to downstream FIFO.
- out_din  out  32  peeled vertex id, zero-extended.
- cfg_k  in  DEG_W  core threshold k; static while in_empty_n activity occurs.
- init_we  in  1  degree table write enable.
- init_addr  in  VID_W  degree table write address.
- init_data  in  DEG_W  degree value to write.
- peel_cnt  out  32  number of vertices pushed downstream since reset.
- err_cnt  out  16  edge words discarded for out-of-range id (saturating).

Behaviour:
- Reset: all table entries 0, in_read=0, out_write=0, out_din=0, peel_cnt=0, err_cnt=0, holding register empty.
- Degree table: register array with combinational read. Read-modify-write completes in the pop cycle, so back-to-back edges to the same vertex see the updated value with no hazard.
- Pop condition: in_read = in_empty_n & ~init_we & (~hold_v | out_full_n), with reset low. Pop happens in the same cycle in_dout is consumed.
- On pop, with vid = in_dout[31:0]:
  - vid >= NUM_V: discard the word; err_cnt+1, saturating at 0xFFFF; no table change.
  - Otherwise old = deg[vid].
    - old == 0: no change; no emission (saturate at 0).
    - old != 0: deg[vid] <= old-1.
    - old == cfg_k and cfg_k != 0: emission.
- Emission: load the holding register (hold_v=1, out_din=vid) at the clock edge ending the pop cycle. out_write rises in the next cycle, so latency is 1 cycle from in_read to out_write.
- out_write = hold_v. The push completes in any cycle where out_write & out_full_n; peel_cnt+1 on each completed push, wrapping at 2^32.
- Holding register update:
  - Transfer and new emission in the same cycle: reload with the new id; hold_v stays 1.
  - Transfer with no new emission: hold_v=0.
  - out_full_n=0: out_din and out_write hold steady; in_read is forced low.
- Init write: when init_we=1, deg[init_addr] <= init_data. Init has priority; popping is blocked that cycle. Writes with init_addr >= NUM_V are ignored.
- cfg_k=0 disables emission; decrements still occur.
- Reset mid-operation: state clears on the next edge; any pending held id is lost; in_read is low during reset.

Optional Feature:
- KCORE_DEG_STATS_EN
- Defined: adds output edge_cnt[31:0], counting every popped word (including discarded ones), wrapping, reset to 0. Also adds output min_deg[DEG_W-1:0], the minimum nonzero decremented degree since reset; reset value all-ones.
- Undefined: neither port exists and no counting logic is built.

Test Plan:
- Init deg[5]=3, cfg_k=3, push edge dst=5 with out_full_n=1 -> in_read pulse, deg[5]=2, next cycle out_write=1 with out_din=5, peel_cnt=1.
- Then two more edges dst=5 -> deg[5]=0, no further out_write; a fourth edge dst=5 -> deg[5] stays 0, no emission.
- Init deg[7]=2, deg[9]=2, cfg_k=2, hold out_full_n=0, push dst=7 then dst=9 -> first popped, out_write=1 with out_din=7 held; second not popped until out_full_n=1. Then 7 pushes, 9 pops and emits the following cycle; peel_cnt=2.
- Push edge dst=64 (NUM_V=64) -> popped, err_cnt=1, table unchanged, no out_write.
- Assert init_we for 3 cycles while in_empty_n=1 -> in_read=0 during those cycles; popping resumes the cycle init_we drops.
- Assert reset while hold_v=1 and out_full_n=0 -> next cycle out_write=0, peel_cnt=0, deg[*]=0.
